// File: rtl/jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_multi
// Description : IEEE 1149.1 TAP controller with generic IR, BYPASS/IDCODE
//               and NumChains user DR chains exposed through parallel
//               capture/update buses. Single clock domain (TCK).
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_multi #(
   parameter int unsigned          IrLength       = 5,
   parameter logic [31:0]          IdcodeValue    = 32'h0000_0001,
   parameter int unsigned          NumChains      = 2,
   parameter int unsigned          DrWidth        = 41,
   parameter int unsigned          UserIrBase     = 'h10,
   parameter logic [IrLength-1:0]  IrCaptureValue = 'b00101
) (
   input  logic                           tck_i,
   input  logic                           trst_i,
   input  logic                           tms_i,
   input  logic                           td_i,
   output logic                           td_o,
   output logic                           tdo_oe_o,
   output logic                           test_logic_reset_o,
   output logic [IrLength-1:0]            ir_o,
   output logic [NumChains-1:0]           chain_sel_o,
   output logic                           capture_dr_o,
   output logic                           shift_dr_o,
   output logic                           update_dr_o,
   input  logic [NumChains*DrWidth-1:0]   cap_data_i,
   output logic [DrWidth-1:0]             upd_data_o,
   output logic [NumChains-1:0]           upd_valid_o
);

   // TAP state encoding
   localparam logic [3:0] c_st_tlr      = 4'd0;
   localparam logic [3:0] c_st_rti      = 4'd1;
   localparam logic [3:0] c_st_sel_dr   = 4'd2;
   localparam logic [3:0] c_st_cap_dr   = 4'd3;
   localparam logic [3:0] c_st_shift_dr = 4'd4;
   localparam logic [3:0] c_st_exit1_dr = 4'd5;
   localparam logic [3:0] c_st_pause_dr = 4'd6;
   localparam logic [3:0] c_st_exit2_dr = 4'd7;
   localparam logic [3:0] c_st_upd_dr   = 4'd8;
   localparam logic [3:0] c_st_sel_ir   = 4'd9;
   localparam logic [3:0] c_st_cap_ir   = 4'd10;
   localparam logic [3:0] c_st_shift_ir = 4'd11;
   localparam logic [3:0] c_st_exit1_ir = 4'd12;
   localparam logic [3:0] c_st_pause_ir = 4'd13;
   localparam logic [3:0] c_st_exit2_ir = 4'd14;
   localparam logic [3:0] c_st_upd_ir   = 4'd15;

   localparam logic [IrLength-1:0] c_ir_idcode = IrLength'(1);

   logic [3:0]           r_state;
   logic [3:0]           w_state_next;
   logic                 w_tlr_load;
   logic [IrLength-1:0]  r_ir;
   logic [IrLength-1:0]  r_ir_shift;
   logic                 r_bypass;
   logic [31:0]          r_idcode;
   logic                 w_sel_idcode;
   logic [NumChains-1:0] w_chain_sel;
   logic [DrWidth-1:0]   r_chain_sr [NumChains];
   logic [DrWidth-1:0]   w_sel_sr;
   logic [DrWidth-1:0]   r_upd_data;
   logic [NumChains-1:0] r_upd_valid;
   logic                 w_td;

   // Standard 1149.1 TMS-driven next-state function
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_tlr:      w_state_next = tms_i ? c_st_tlr      : c_st_rti;
         c_st_rti:      w_state_next = tms_i ? c_st_sel_dr   : c_st_rti;
         c_st_sel_dr:   w_state_next = tms_i ? c_st_sel_ir   : c_st_cap_dr;
         c_st_cap_dr:   w_state_next = tms_i ? c_st_exit1_dr : c_st_shift_dr;
         c_st_shift_dr: w_state_next = tms_i ? c_st_exit1_dr : c_st_shift_dr;
         c_st_exit1_dr: w_state_next = tms_i ? c_st_upd_dr   : c_st_pause_dr;
         c_st_pause_dr: w_state_next = tms_i ? c_st_exit2_dr : c_st_pause_dr;
         c_st_exit2_dr: w_state_next = tms_i ? c_st_upd_dr   : c_st_shift_dr;
         c_st_upd_dr:   w_state_next = tms_i ? c_st_sel_dr   : c_st_rti;
         c_st_sel_ir:   w_state_next = tms_i ? c_st_tlr      : c_st_cap_ir;
         c_st_cap_ir:   w_state_next = tms_i ? c_st_exit1_ir : c_st_shift_ir;
         c_st_shift_ir: w_state_next = tms_i ? c_st_exit1_ir : c_st_shift_ir;
         c_st_exit1_ir: w_state_next = tms_i ? c_st_upd_ir   : c_st_pause_ir;
         c_st_pause_ir: w_state_next = tms_i ? c_st_exit2_ir : c_st_pause_ir;
         c_st_exit2_ir: w_state_next = tms_i ? c_st_upd_ir   : c_st_shift_ir;
         c_st_upd_ir:   w_state_next = tms_i ? c_st_sel_dr   : c_st_rti;
         default:       w_state_next = c_st_tlr;
      endcase
   end

   // Reset-state register loads happen as Test-Logic-Reset is entered so the
   // IDCODE instruction is already visible during the first TLR cycle.
   assign w_tlr_load = trst_i || (w_state_next == c_st_tlr);

   // TAP state register
   always_ff @(posedge tck_i) begin
      if (trst_i) r_state <= c_st_tlr;
      else        r_state <= w_state_next;
   end

   // Instruction shift register and instruction latch
   always_ff @(posedge tck_i) begin
      if (w_tlr_load) begin
         r_ir_shift <= '0;
         r_ir       <= c_ir_idcode;
      end else begin
         case (r_state)
            c_st_cap_ir:   r_ir_shift <= IrCaptureValue;
            c_st_shift_ir: r_ir_shift <= {td_i, r_ir_shift[IrLength-1:1]};
            c_st_upd_ir:   r_ir       <= r_ir_shift;
            default:       ;
         endcase
      end
   end

   // Instruction decode: IDCODE plus one comparator per user chain; all
   // remaining codes fall through to BYPASS.
   assign w_sel_idcode = (r_ir == c_ir_idcode);

   for (genvar k = 0; k < NumChains; k++) begin : g_chain_dec
      localparam logic [IrLength-1:0] c_code = IrLength'(UserIrBase + k);
      assign w_chain_sel[k] = (r_ir == c_code);
   end

   // BYPASS and IDCODE data registers
   always_ff @(posedge tck_i) begin
      if (w_tlr_load) begin
         r_bypass <= 1'b0;
         r_idcode <= IdcodeValue;
      end else if (r_state == c_st_cap_dr) begin
         r_bypass <= 1'b0;
         if (w_sel_idcode) r_idcode <= IdcodeValue;
      end else if (r_state == c_st_shift_dr) begin
         r_bypass <= td_i;
         if (w_sel_idcode) r_idcode <= {td_i, r_idcode[31:1]};
      end
   end

   // User chain shift registers; only the selected chain captures or shifts,
   // and a TRST in mid-shift drops the pending bit.
   always_ff @(posedge tck_i) begin
      for (int k = 0; k < NumChains; k++) begin
         if (!trst_i && w_chain_sel[k]) begin
            if (r_state == c_st_cap_dr)
               r_chain_sr[k] <= cap_data_i[k*DrWidth +: DrWidth];
            else if (r_state == c_st_shift_dr)
               r_chain_sr[k] <= (r_chain_sr[k] >> 1)
                              | (DrWidth'(td_i) << (DrWidth-1));
         end
      end
   end

   // Contents of whichever user chain is currently selected
   always_comb begin
      w_sel_sr = '0;
      for (int k = 0; k < NumChains; k++)
         if (w_chain_sel[k]) w_sel_sr = r_chain_sr[k];
   end

   // Parallel update word and per-chain valid pulse
   always_ff @(posedge tck_i) begin
      if (trst_i) begin
         r_upd_data  <= '0;
         r_upd_valid <= '0;
      end else begin
         r_upd_valid <= '0;
         if ((r_state == c_st_upd_dr) && (|w_chain_sel)) begin
            r_upd_data  <= w_sel_sr;
            r_upd_valid <= w_chain_sel;
         end
      end
   end

   // TDO mux, driven only from registered state
   always_comb begin
      w_td = 1'b0;
      case (r_state)
         c_st_shift_ir: w_td = r_ir_shift[0];
         c_st_shift_dr: begin
            if (|w_chain_sel)      w_td = w_sel_sr[0];
            else if (w_sel_idcode) w_td = r_idcode[0];
            else                   w_td = r_bypass;
         end
         default:       w_td = 1'b0;
      endcase
   end

   assign td_o               = w_td;
   assign tdo_oe_o           = (r_state == c_st_shift_ir) || (r_state == c_st_shift_dr);
   assign test_logic_reset_o = (r_state == c_st_tlr);
   assign ir_o               = r_ir;
   assign chain_sel_o        = w_chain_sel;
   assign capture_dr_o       = (r_state == c_st_cap_dr);
   assign shift_dr_o         = (r_state == c_st_shift_dr);
   assign update_dr_o        = (r_state == c_st_upd_dr);
   assign upd_data_o         = r_upd_data;
   assign upd_valid_o        = r_upd_valid;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_multi
// Description : Directed + randomized self-checking bench for jtag_tap_multi.
//               DR/IR scans are predicted with a FIFO model of the shift path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_multi;

   localparam int          IR_LEN   = 5;
   localparam int          NCH      = 2;
   localparam int          DRW      = 41;
   localparam int          UIR_BASE = 'h10;
   localparam logic [31:0] IDCODE   = 32'h0000_0001;
   localparam logic [4:0]  IR_CAP   = 5'b00101;

   logic                 tck_i = 1'b0;
   logic                 trst_i, tms_i, td_i;
   logic                 td_o, tdo_oe_o, test_logic_reset_o;
   logic [IR_LEN-1:0]    ir_o;
   logic [NCH-1:0]       chain_sel_o, upd_valid_o;
   logic                 capture_dr_o, shift_dr_o, update_dr_o;
   logic [NCH*DRW-1:0]   cap_data_i;
   logic [DRW-1:0]       upd_data_o;

   int n_assert = 0;
   int n_fail   = 0;

   jtag_tap_multi #(
      .IrLength(IR_LEN), .IdcodeValue(IDCODE), .NumChains(NCH),
      .DrWidth(DRW), .UserIrBase(UIR_BASE), .IrCaptureValue(IR_CAP)
   ) dut (
      .tck_i(tck_i), .trst_i(trst_i), .tms_i(tms_i), .td_i(td_i),
      .td_o(td_o), .tdo_oe_o(tdo_oe_o), .test_logic_reset_o(test_logic_reset_o),
      .ir_o(ir_o), .chain_sel_o(chain_sel_o), .capture_dr_o(capture_dr_o),
      .shift_dr_o(shift_dr_o), .update_dr_o(update_dr_o),
      .cap_data_i(cap_data_i), .upd_data_o(upd_data_o), .upd_valid_o(upd_valid_o)
   );

   always #5 tck_i = ~tck_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One TCK cycle: drive inputs, wait for the rising edge, settle.
   task automatic clk1(input logic tms, input logic tdi);
      tms_i = tms;
      td_i  = tdi;
      @(posedge tck_i);
      #1;
   endtask

   // A shift register seen as a FIFO: captured bits leave first, shifted-in
   // bits join the tail, and the final register is the tail of width w.
   function automatic void model(input logic [127:0] cap, input int w,
                                 input logic [127:0] din, input int n,
                                 output logic [127:0] dout, output logic [127:0] fin);
      logic q[$];
      dout = '0;
      fin  = '0;
      for (int i = 0; i < w; i++) q.push_back(cap[i]);
      for (int i = 0; i < n; i++) begin
         dout[i] = q.pop_front();
         q.push_back(din[i]);
      end
      for (int i = 0; i < w; i++) fin[i] = q[i];
   endfunction

   // IR scan from Run-Test/Idle, ends back in Run-Test/Idle.
   task automatic ir_scan(input logic [IR_LEN-1:0] v, output logic [IR_LEN-1:0] dout);
      dout = '0;
      clk1(1, 0); clk1(1, 0); clk1(0, 0); clk1(0, 0);
      for (int i = 0; i < IR_LEN; i++) begin
         dout[i] = td_o;
         clk1(i == IR_LEN-1, v[i]);
      end
      clk1(1, 0);
      clk1(0, 0);
   endtask

   // DR scan from Run-Test/Idle, ends in Update-DR. Optional 3-cycle pause
   // after bit pause_at-1.
   task automatic dr_scan(input int n, input logic [127:0] din, input int pause_at,
                          output logic [127:0] dout, output int oe_cnt);
      dout   = '0;
      oe_cnt = 0;
      clk1(1, 0);
      clk1(0, 0);
      chk("capture_dr_strobe", capture_dr_o, 1);
      if (n == 0) begin
         clk1(1, 0);
      end else begin
         clk1(0, 0);
         chk("shift_dr_strobe", shift_dr_o, 1);
         for (int i = 0; i < n; i++) begin
            dout[i] = td_o;
            oe_cnt += int'(tdo_oe_o);
            if (pause_at > 0 && i == pause_at-1) begin
               clk1(1, din[i]);
               clk1(0, 0); clk1(0, 0); clk1(0, 0);
               oe_cnt += int'(tdo_oe_o);
               clk1(1, 0);
               clk1(0, 0);
            end else begin
               clk1(i == n-1, din[i]);
            end
         end
         oe_cnt += int'(tdo_oe_o);
      end
      clk1(1, 0);
      chk("update_dr_strobe", update_dr_o, 1);
   endtask

   logic [IR_LEN-1:0] ir_out;
   logic [127:0]      dout, exp_out, exp_reg, cap, din, mask;
   logic [DRW-1:0]    last_upd;
   int                oe_cnt, k, n;

   initial begin
      trst_i = 1; tms_i = 1; td_i = 0; cap_data_i = '0;
      mask = (128'd1 << DRW) - 1;

      // Reset state
      clk1(1, 0);
      chk("rst_tlr", test_logic_reset_o, 1);
      chk("rst_ir", ir_o, 1);
      chk("rst_chain_sel", chain_sel_o, 0);
      chk("rst_upd_data", upd_data_o, 0);
      chk("rst_upd_valid", upd_valid_o, 0);
      chk("rst_td_o", td_o, 0);
      chk("rst_tdo_oe", tdo_oe_o, 0);
      chk("rst_strobes", {capture_dr_o, shift_dr_o, update_dr_o}, 0);
      trst_i = 0;
      last_upd = '0;

      clk1(0, 0);
      chk("rti_tlr_low", test_logic_reset_o, 0);
      chk("rti_ir", ir_o, 1);

      // IDCODE scan
      model({96'd0, IDCODE}, 32, 128'd0, 32, exp_out, exp_reg);
      dr_scan(32, 128'd0, 0, dout, oe_cnt);
      chk("idcode_tdo", dout, exp_out);
      chk("idcode_oe_cycles", oe_cnt, 32);
      clk1(0, 0);
      chk("idcode_no_upd", upd_valid_o, 0);

      // IR scan to chain 0
      ir_scan(5'h10, ir_out);
      chk("ir_capture_tdo", ir_out, IR_CAP);
      chk("ir_after_upd", ir_o, 5'h10);
      chk("chain_sel_0", chain_sel_o, 2'b01);

      // Chain 0 directed pattern
      cap = 128'h155_5555_5555;
      din = 128'h0AA_AAAA_AAAA;
      cap_data_i[0 +: DRW] = cap[DRW-1:0];
      model(cap, DRW, din, DRW, exp_out, exp_reg);
      dr_scan(DRW, din, 0, dout, oe_cnt);
      chk("c0_tdo", dout, exp_out);
      clk1(0, 0);
      chk("c0_upd_valid", upd_valid_o, 2'b01);
      chk("c0_upd_data", upd_data_o, exp_reg);
      last_upd = exp_reg[DRW-1:0];
      clk1(0, 0);
      chk("c0_upd_valid_drop", upd_valid_o, 0);
      chk("c0_upd_data_hold", upd_data_o, last_upd);

      // Exit1-DR straight from Capture-DR writes the captured word
      cap = {$urandom, $urandom, $urandom, $urandom} & mask;
      cap_data_i[0 +: DRW] = cap[DRW-1:0];
      dr_scan(0, 128'd0, 0, dout, oe_cnt);
      clk1(0, 0);
      chk("c0_nullscan_valid", upd_valid_o, 2'b01);
      chk("c0_nullscan_data", upd_data_o, cap);
      last_upd = cap[DRW-1:0];

      // Randomized scans on random chains, lengths up to DrWidth+8
      for (int it = 0; it < 6; it++) begin
         k = int'($urandom_range(0, NCH-1));
         n = int'($urandom_range(1, DRW+8));
         ir_scan(IR_LEN'(UIR_BASE + k), ir_out);
         chk("rnd_chain_sel", chain_sel_o, 128'd1 << k);
         cap = {$urandom, $urandom, $urandom, $urandom} & mask;
         din = {$urandom, $urandom, $urandom, $urandom};
         cap_data_i[k*DRW +: DRW] = cap[DRW-1:0];
         model(cap, DRW, din, n, exp_out, exp_reg);
         dr_scan(n, din, 0, dout, oe_cnt);
         chk("rnd_tdo", dout, exp_out);
         clk1(0, 0);
         chk("rnd_upd_valid", upd_valid_o, 128'd1 << k);
         chk("rnd_upd_data", upd_data_o, exp_reg);
         last_upd = exp_reg[DRW-1:0];
      end

      // Chain 1 with a Pause-DR in the middle
      ir_scan(5'h11, ir_out);
      chk("chain_sel_1", chain_sel_o, 2'b10);
      cap = {$urandom, $urandom} & mask;
      din = {$urandom, $urandom} & mask;
      cap_data_i[DRW +: DRW] = cap[DRW-1:0];
      model(cap, DRW, din, DRW, exp_out, exp_reg);
      dr_scan(DRW, din, 20, dout, oe_cnt);
      chk("pause_tdo", dout, exp_out);
      chk("pause_oe_cycles", oe_cnt, DRW);
      clk1(0, 0);
      chk("pause_upd_valid", upd_valid_o, 2'b10);
      chk("pause_upd_data", upd_data_o, din);
      last_upd = din[DRW-1:0];

      // Unmapped code falls back to BYPASS
      ir_scan(5'h17, ir_out);
      chk("bypass_chain_sel", chain_sel_o, 0);
      model(128'd0, 1, 128'hC3, 8, exp_out, exp_reg);
      dr_scan(8, 128'hC3, 0, dout, oe_cnt);
      chk("bypass_tdo", dout, exp_out);
      clk1(0, 0);
      chk("bypass_no_upd", upd_valid_o, 0);
      chk("bypass_upd_hold", upd_data_o, last_upd);

      // Five TMS=1 cycles from mid Shift-DR reach Test-Logic-Reset
      ir_scan(5'h10, ir_out);
      clk1(1, 0); clk1(0, 0); clk1(0, 0);
      clk1(0, 1); clk1(0, 0); clk1(0, 1);
      for (int i = 0; i < 5; i++) clk1(1, 0);
      chk("tms_tlr", test_logic_reset_o, 1);
      chk("tms_ir", ir_o, 1);
      chk("tms_chain_sel", chain_sel_o, 0);
      chk("tms_no_pulse", upd_valid_o, 0);
      clk1(0, 0);

      // TRST in mid Shift-DR: one cycle to Test-Logic-Reset, shift discarded
      ir_scan(5'h10, ir_out);
      clk1(1, 0); clk1(0, 0); clk1(0, 0);
      clk1(0, 1); clk1(0, 1);
      trst_i = 1;
      clk1(0, 0);
      trst_i = 0;
      chk("trst_tlr", test_logic_reset_o, 1);
      chk("trst_ir", ir_o, 1);
      chk("trst_upd_valid", upd_valid_o, 0);
      chk("trst_upd_data", upd_data_o, 0);
      chk("trst_tdo_oe", tdo_oe_o, 0);
      clk1(0, 0);
      chk("trst_no_late_pulse", upd_valid_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
